// File: rtl/sram_march_bist_ctrl.sv
// March C- built-in-self-test sequencer for the QDI SRAM test bank.
// Drives binary requests into the bank's Bin2QDI decoders with a four-phase
// GO/accept handshake, checks read words from the QDI2Bin encoders against
// the expected background and reports pass/fail/timeout/abort.
module sram_march_bist_ctrl #(
  parameter int AW      = 10,
  parameter int DW      = 4,
  parameter int EW      = 16,
  parameter int TIMEOUT = 1023,
  parameter int SYNC    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  inout  wire           VDD,
  inout  wire           GND,
  input  logic          START,
  input  logic          ABORT,
  input  logic          BG,
  output logic          GO,
  output logic          RW,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] WDATA,
  input  logic          ACCEPT_N,
  input  logic          RVALID,
  input  logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic [1:0]    STATUS,
  output logic [EW-1:0] ERR_COUNT,
  output logic [AW-1:0] FAIL_ADDR
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(DW + 1);
  localparam int SW = ((EW > PW) ? EW : PW) + 1;
  localparam logic [EW-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RELEASE, S_NEXT, S_FINISH, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ST_PASS = 2'b00, ST_FAIL = 2'b01, ST_TIMEOUT = 2'b10, ST_ABORT = 2'b11
  } status_e;

  state_e          r_state, w_state_next;
  status_e         r_status;
  logic [SYNC-1:0] r_acc_sync, r_rv_sync;
  logic [2:0]      r_elem;            // March element M0..M5
  logic            r_op;              // op index within the element
  logic [AW-1:0]   r_addr;
  logic            r_bg;              // background latched at START
  logic            r_abort;
  logic [TW-1:0]   r_tmo_cnt;
  logic [EW-1:0]   r_err;
  logic [AW-1:0]   r_fail_addr;

  logic            w_acc_s, w_rv_s;
  logic            w_is_read, w_inv, w_down;
  logic            w_last_op, w_last_addr, w_last_all;
  logic            w_hs_done, w_released, w_tmo_fire, w_abort_seen;
  logic [DW-1:0]   w_expect, w_err_bits;
  logic [PW-1:0]   w_pop;
  logic [SW-1:0]   w_sum;
  logic            w_unused_supply;

  assign w_unused_supply = VDD ^ GND;

  // Synchronize the asynchronous bank handshake inputs; reset to neutral.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_acc_sync <= '1;
      r_rv_sync  <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      r_acc_sync <= {r_acc_sync[SYNC-2:0], ACCEPT_N};
      r_rv_sync  <= {r_rv_sync[SYNC-2:0], RVALID};
    end
  end

  assign w_acc_s = r_acc_sync[SYNC-1];
  assign w_rv_s  = r_rv_sync[SYNC-1];

  // Decode the current March op from the element/op pointers.
  assign w_is_read   = (r_elem != 3'd0) && !r_op;
  assign w_inv       = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? r_op :
                       ((r_elem == 3'd2) || (r_elem == 3'd4)) ? !r_op : 1'b0;
  assign w_down      = (r_elem >= 3'd3);
  assign w_last_op   = (r_elem == 3'd0) || (r_elem == 3'd5) || r_op;
  assign w_last_addr = w_down ? (r_addr == '0) : (r_addr == '1);
  assign w_last_all  = w_last_op && w_last_addr && (r_elem == 3'd5);
  assign w_expect    = {DW{r_bg ^ w_inv}};

  assign w_hs_done    = !w_acc_s && (!w_is_read || w_rv_s);
  assign w_released   = w_acc_s && !w_rv_s;
  assign w_abort_seen = r_abort || ABORT;
  assign w_tmo_fire   = (r_tmo_cnt == TW'(TIMEOUT - 1)) &&
                        (((r_state == S_ISSUE) && !w_hs_done) ||
                         ((r_state == S_RELEASE) && !w_released));

  // Bit-error count of the word being read, saturating accumulate.
  assign w_err_bits = RDATA ^ w_expect;
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    w_pop = '0;
    for (int i = 0; i < DW; i++) w_pop = w_pop + PW'(w_err_bits[i]);
  end
  assign w_sum = SW'(r_err) + SW'(w_pop);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (START && w_acc_s && !w_rv_s) w_state_next = S_ISSUE;
      S_ISSUE:   if (w_hs_done)       w_state_next = S_RELEASE;
                 else if (w_tmo_fire) w_state_next = S_FINISH;
      S_RELEASE: if (w_released)      w_state_next = S_NEXT;
                 else if (w_tmo_fire) w_state_next = S_FINISH;
      S_NEXT:    w_state_next = (w_last_all || w_abort_seen) ? S_FINISH : S_ISSUE;
      S_FINISH:  w_state_next = (r_status == ST_TIMEOUT) ? S_HALT : S_IDLE;
      S_HALT:    w_state_next = S_HALT;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    GO        = (r_state == S_ISSUE);
    BUSY      = (r_state == S_ISSUE) || (r_state == S_RELEASE) || (r_state == S_NEXT);
    DONE      = (r_state == S_FINISH);
    RW        = w_is_read;
    ADDR      = r_addr;
    WDATA     = w_expect;
    STATUS    = r_status;
    ERR_COUNT = r_err;
    FAIL_ADDR = r_fail_addr;
  end

  // Per-phase timeout counter, cleared on every entry to ISSUE or RELEASE.
  always_ff @(posedge CLK) begin
    if (RESET) r_tmo_cnt <= '0;
    else if ((w_state_next == r_state) &&
             ((r_state == S_ISSUE) || (r_state == S_RELEASE)))
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    else r_tmo_cnt <= '0;
  end

  // Run datapath: pointers, abort latch, error accounting, final status.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_elem      <= '0;
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_bg        <= 1'b0;
      r_abort     <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_status    <= ST_PASS;
    end else begin
      if (BUSY) r_abort <= w_abort_seen;
      case (r_state)
        S_IDLE: if (w_state_next == S_ISSUE) begin
          r_elem      <= '0;
          r_op        <= 1'b0;
          r_addr      <= '0;
          r_bg        <= BG;
          r_abort     <= 1'b0;
          r_err       <= '0;
          r_fail_addr <= '0;
          r_status    <= ST_PASS;
        end
        S_ISSUE, S_RELEASE: begin
          if ((r_state == S_ISSUE) && w_hs_done && w_is_read) begin
            r_err <= (w_sum > SW'(ERR_MAX)) ? ERR_MAX : w_sum[EW-1:0];
            if ((w_err_bits != '0) && (r_err == '0)) r_fail_addr <= r_addr;
          end
          if (w_tmo_fire) r_status <= ST_TIMEOUT;
        end
        S_NEXT: begin
          if (w_state_next == S_FINISH)
            r_status <= w_abort_seen ? ST_ABORT : ((r_err != '0) ? ST_FAIL : ST_PASS);
          else if (!w_last_op) r_op <= 1'b1;
          else begin
            r_op <= 1'b0;
            if (w_last_addr) begin
              // Elements M3..M5 walk downwards, so M2->M3 restarts at the top.
              r_elem <= r_elem + 3'd1;
              r_addr <= (r_elem >= 3'd2) ? '1 : '0;
            end else begin
              r_addr <= w_down ? (r_addr - AW'(1)) : (r_addr + AW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
